// File: rtl/sc_reg_general_level_mode_pkg.sv
// Shared encodings for the game-level register: operation codes and bus widths.
package sc_level_pkg;

    localparam int OP_WIDTH = 3;

    localparam logic [OP_WIDTH-1:0] OP_HOLD = 3'b000;
    localparam logic [OP_WIDTH-1:0] OP_INC  = 3'b001;
    localparam logic [OP_WIDTH-1:0] OP_DEC  = 3'b010;
    localparam logic [OP_WIDTH-1:0] OP_ROL  = 3'b011;
    localparam logic [OP_WIDTH-1:0] OP_ROR  = 3'b100;
    localparam logic [OP_WIDTH-1:0] OP_SHL1 = 3'b101;
    localparam logic [OP_WIDTH-1:0] OP_SHR0 = 3'b110;

endpackage

// File: rtl/sc_reg_general_level_mode_if.sv
// Command/status bundle between the game FSM (master) and the level register (slave).
interface sc_reg_general_level_mode_if #(
    parameter int DATAWIDTH = 4
);
    import sc_level_pkg::*;

    logic                 SC_RegLEVEL_clear_InLow;
    logic                 SC_RegLEVEL_load_InLow;
    logic [OP_WIDTH-1:0]  SC_RegLEVEL_op_InBUS;
    logic                 SC_RegLEVEL_autoEn_InHigh;
    logic [DATAWIDTH-1:0] SC_RegLEVEL_data_InBUS;
    logic [DATAWIDTH-1:0] SC_RegLEVEL_data_OutBUS;
    logic                 SC_RegLEVEL_max_OutHigh;
    logic                 SC_RegLEVEL_min_OutHigh;
    logic                 SC_RegLEVEL_changed_OutHigh;

    modport master (
        output SC_RegLEVEL_clear_InLow, SC_RegLEVEL_load_InLow, SC_RegLEVEL_op_InBUS,
               SC_RegLEVEL_autoEn_InHigh, SC_RegLEVEL_data_InBUS,
        input  SC_RegLEVEL_data_OutBUS, SC_RegLEVEL_max_OutHigh, SC_RegLEVEL_min_OutHigh,
               SC_RegLEVEL_changed_OutHigh
    );

    modport slave (
        input  SC_RegLEVEL_clear_InLow, SC_RegLEVEL_load_InLow, SC_RegLEVEL_op_InBUS,
               SC_RegLEVEL_autoEn_InHigh, SC_RegLEVEL_data_InBUS,
        output SC_RegLEVEL_data_OutBUS, SC_RegLEVEL_max_OutHigh, SC_RegLEVEL_min_OutHigh,
               SC_RegLEVEL_changed_OutHigh
    );

endinterface

// File: rtl/sc_reg_general_level_mode_tick_divider.sv
// Free-running 0..TICKS-1 counter; wrap is high during the cycle whose edge rolls it back to 0.
module sc_tick_divider #(
    parameter int TICKS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int CW = (TICKS > 2) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] count_r;

    assign wrap = en && (count_r == LAST);

    // Counter register: held at zero while disabled or cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (clr || !en) begin
            count_r <= {CW{1'b0}};
        end else if (count_r == LAST) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

endmodule

// File: rtl/sc_reg_general_level_mode.sv
// Level/pattern register with saturating inc/dec, rotates, fill-shifts and timed auto-advance.
module sc_reg_general_level_mode
    import sc_level_pkg::*;
#(
    parameter int DATAWIDTH  = 4,
    parameter int INIT_VALUE = 0,
    parameter int MAX_LEVEL  = 9,
    parameter int TICKS      = 8
) (
    input  logic                        SC_RegLEVEL_CLOCK_50,
    input  logic                        SC_RegLEVEL_RESET_InHigh,
    sc_reg_general_level_mode_if.slave  levelBus
);

    localparam logic [DATAWIDTH-1:0] MAX_W  = DATAWIDTH'(MAX_LEVEL);
    localparam logic [DATAWIDTH-1:0] INIT_W = DATAWIDTH'(INIT_VALUE);
    localparam logic [DATAWIDTH-1:0] ZERO_W = {DATAWIDTH{1'b0}};

    logic [DATAWIDTH-1:0] word_r;
    logic [DATAWIDTH-1:0] wordNext_s;
    logic                 changed_r;
    logic                 max_r;
    logic                 min_r;
    logic                 divClear_s;
    logic                 advance_s;

    function automatic logic [DATAWIDTH-1:0] satInc(input logic [DATAWIDTH-1:0] w);
        return (w >= MAX_W) ? w : w + DATAWIDTH'(1);
    endfunction

    function automatic logic [DATAWIDTH-1:0] satDec(input logic [DATAWIDTH-1:0] w);
        return (w == ZERO_W) ? w : w - DATAWIDTH'(1);
    endfunction

    sc_tick_divider #(.TICKS(TICKS)) tickDivider (
        .clk  (SC_RegLEVEL_CLOCK_50),
        .rst  (SC_RegLEVEL_RESET_InHigh),
        .en   (levelBus.SC_RegLEVEL_autoEn_InHigh),
        .clr  (divClear_s),
        .wrap (advance_s)
    );

    // Next-word selection; an advance only lands when no command owns this edge.
    always_comb begin
        wordNext_s = word_r;
        divClear_s = 1'b0;
        if (!levelBus.SC_RegLEVEL_clear_InLow) begin
            wordNext_s = INIT_W;
            divClear_s = 1'b1;
        end else if (!levelBus.SC_RegLEVEL_load_InLow) begin
            wordNext_s = (levelBus.SC_RegLEVEL_data_InBUS > MAX_W) ? MAX_W
                                                                  : levelBus.SC_RegLEVEL_data_InBUS;
            divClear_s = 1'b1;
        end else begin
            case (levelBus.SC_RegLEVEL_op_InBUS)
                OP_INC:  wordNext_s = satInc(word_r);
                OP_DEC:  wordNext_s = satDec(word_r);
                OP_ROL:  wordNext_s = {word_r[DATAWIDTH-2:0], word_r[DATAWIDTH-1]};
                OP_ROR:  wordNext_s = {word_r[0], word_r[DATAWIDTH-1:1]};
                OP_SHL1: wordNext_s = {word_r[DATAWIDTH-2:0], 1'b1};
                OP_SHR0: wordNext_s = {1'b0, word_r[DATAWIDTH-1:1]};
                default: begin
                    if (advance_s) begin
                        wordNext_s = satInc(word_r);
                    end else begin
                        wordNext_s = word_r;
                    end
                end
            endcase
        end
    end

    // Word and status flags are registered together so they always describe the same value.
    always_ff @(posedge SC_RegLEVEL_CLOCK_50) begin
        if (SC_RegLEVEL_RESET_InHigh) begin
            word_r    <= ZERO_W;
            changed_r <= 1'b0;
            max_r     <= 1'b0;
            min_r     <= 1'b1;
        end else begin
            word_r    <= wordNext_s;
            changed_r <= (wordNext_s != word_r);
            max_r     <= (wordNext_s >= MAX_W);
            min_r     <= (wordNext_s == ZERO_W);
        end
    end

    assign levelBus.SC_RegLEVEL_data_OutBUS     = word_r;
    assign levelBus.SC_RegLEVEL_changed_OutHigh = changed_r;
    assign levelBus.SC_RegLEVEL_max_OutHigh     = max_r;
    assign levelBus.SC_RegLEVEL_min_OutHigh     = min_r;

endmodule

// File: tb/tb_sc_reg_general_level_mode.sv
// Directed bench for the level register: W=4, INIT=5, MAX=9, TICKS=8.
module tb_sc_reg_general_level_mode;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [6:0] obs;
    logic [6:0] exp;

    sc_reg_general_level_mode_if #(.DATAWIDTH(4)) levelBus ();

    sc_reg_general_level_mode #(
        .DATAWIDTH(4), .INIT_VALUE(5), .MAX_LEVEL(9), .TICKS(8)
    ) dut (
        .SC_RegLEVEL_CLOCK_50     (clk),
        .SC_RegLEVEL_RESET_InHigh (rst),
        .levelBus                 (levelBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // obs packs {data, max, min, changed}
    task automatic tick();
        @(posedge clk);
        #1;
        obs = {levelBus.SC_RegLEVEL_data_OutBUS, levelBus.SC_RegLEVEL_max_OutHigh,
               levelBus.SC_RegLEVEL_min_OutHigh, levelBus.SC_RegLEVEL_changed_OutHigh};
    endtask

    task automatic idle();
        levelBus.SC_RegLEVEL_clear_InLow   = 1'b1;
        levelBus.SC_RegLEVEL_load_InLow    = 1'b1;
        levelBus.SC_RegLEVEL_op_InBUS      = 3'b000;
        levelBus.SC_RegLEVEL_autoEn_InHigh = 1'b0;
        levelBus.SC_RegLEVEL_data_InBUS    = 4'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        levelBus.SC_RegLEVEL_clear_InLow   = 1'b0;
        levelBus.SC_RegLEVEL_load_InLow    = 1'b0;
        levelBus.SC_RegLEVEL_op_InBUS      = 3'b001;
        levelBus.SC_RegLEVEL_autoEn_InHigh = 1'b1;
        levelBus.SC_RegLEVEL_data_InBUS    = 4'd15;
        tick();
        tick();
        checks++;
        if (obs !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset obs=%b exp=%b", obs, {4'd0, 1'b0, 1'b1, 1'b0});
        end
        rst = 1'b0;
        idle();
        levelBus.SC_RegLEVEL_clear_InLow = 1'b0;
        tick();
        checks++;
        if (obs !== {4'd5, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL clear obs=%b exp=%b", obs, {4'd5, 1'b0, 1'b0, 1'b1});
        end
        // clear and load together: clear wins; repeat clear gives no pulse
        levelBus.SC_RegLEVEL_load_InLow = 1'b0;
        levelBus.SC_RegLEVEL_data_InBUS = 4'd3;
        tick();
        checks++;
        if (obs !== {4'd5, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL clear_over_load obs=%b exp=%b", obs, {4'd5, 1'b0, 1'b0, 1'b0});
        end
        idle();
        levelBus.SC_RegLEVEL_load_InLow = 1'b0;
        levelBus.SC_RegLEVEL_data_InBUS = 4'd5;
        tick();
        checks++;
        if (obs !== {4'd5, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL load_same obs=%b exp=%b", obs, {4'd5, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_saturate();
        logic [3:0] w;
        idle();
        levelBus.SC_RegLEVEL_load_InLow = 1'b0;
        levelBus.SC_RegLEVEL_data_InBUS = 4'd15;
        levelBus.SC_RegLEVEL_op_InBUS   = 3'b010;
        tick();
        checks++;
        if (obs !== {4'd9, 1'b1, 1'b0, 1'b1}) begin
            errors++; $display("FAIL load_clamp obs=%b exp=%b", obs, {4'd9, 1'b1, 1'b0, 1'b1});
        end
        idle();
        levelBus.SC_RegLEVEL_op_InBUS = 3'b001;
        tick();
        checks++;
        if (obs !== {4'd9, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL inc_sat obs=%b exp=%b", obs, {4'd9, 1'b1, 1'b0, 1'b0});
        end
        levelBus.SC_RegLEVEL_op_InBUS = 3'b010;
        w = 4'd9;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp = {(w == 4'd0) ? 4'd0 : w - 4'd1, 1'b0, (w <= 4'd1), (w != 4'd0)};
            w = (w == 4'd0) ? 4'd0 : w - 4'd1;
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL dec_%0d obs=%b exp=%b", i, obs, exp);
            end
        end
    endtask

    task automatic test_rotate_shift();
        logic [3:0] seq [0:3];
        idle();
        levelBus.SC_RegLEVEL_load_InLow = 1'b0;
        levelBus.SC_RegLEVEL_data_InBUS = 4'b1001;
        tick();
        idle();
        levelBus.SC_RegLEVEL_op_InBUS = 3'b011;
        tick();
        checks++;
        if (obs !== {4'b0011, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL rol1 obs=%b exp=%b", obs, {4'b0011, 1'b0, 1'b0, 1'b1});
        end
        tick();
        checks++;
        if (obs !== {4'b0110, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL rol2 obs=%b exp=%b", obs, {4'b0110, 1'b0, 1'b0, 1'b1});
        end
        levelBus.SC_RegLEVEL_op_InBUS = 3'b100;
        tick();
        checks++;
        if (obs !== {4'b0011, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL ror obs=%b exp=%b", obs, {4'b0011, 1'b0, 1'b0, 1'b1});
        end
        idle();
        levelBus.SC_RegLEVEL_load_InLow = 1'b0;
        tick();
        idle();
        levelBus.SC_RegLEVEL_op_InBUS = 3'b101;
        seq[0] = 4'b0001; seq[1] = 4'b0011; seq[2] = 4'b0111; seq[3] = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = {seq[i], (i == 3), 1'b0, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL shl1_%0d obs=%b exp=%b", i, obs, exp);
            end
        end
        levelBus.SC_RegLEVEL_op_InBUS = 3'b110;
        tick();
        checks++;
        if (obs !== {4'b0111, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL shr0 obs=%b exp=%b", obs, {4'b0111, 1'b0, 1'b0, 1'b1});
        end
        levelBus.SC_RegLEVEL_op_InBUS = 3'b111;
        tick();
        checks++;
        if (obs !== {4'b0111, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL hold111 obs=%b exp=%b", obs, {4'b0111, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_auto();
        logic [3:0] w;
        idle();
        levelBus.SC_RegLEVEL_load_InLow = 1'b0;
        tick();
        idle();
        levelBus.SC_RegLEVEL_autoEn_InHigh = 1'b1;
        for (int e = 0; e < 24; e++) begin
            tick();
            w = 4'((e + 1) / 8);
            exp = {w, 1'b0, (w == 4'd0), ((e + 1) % 8 == 0)};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL auto_e%0d obs=%b exp=%b", e, obs, exp);
            end
        end
        idle();
        levelBus.SC_RegLEVEL_load_InLow = 1'b0;
        tick();
        idle();
        levelBus.SC_RegLEVEL_autoEn_InHigh = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
        end
        levelBus.SC_RegLEVEL_autoEn_InHigh = 1'b0;
        tick();
        checks++;
        if (obs !== {4'd1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL auto_drop obs=%b exp=%b", obs, {4'd1, 1'b0, 1'b0, 1'b0});
        end
        levelBus.SC_RegLEVEL_autoEn_InHigh = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            exp = {(j == 7) ? 4'd2 : 4'd1, 1'b0, 1'b0, (j == 7)};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL auto_reen_%0d obs=%b exp=%b", j, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        idle();
        levelBus.SC_RegLEVEL_load_InLow = 1'b0;
        tick();
        idle();
        levelBus.SC_RegLEVEL_autoEn_InHigh = 1'b1;
        for (int e = 0; e < 7; e++) tick();
        levelBus.SC_RegLEVEL_op_InBUS = 3'b001;
        tick();
        checks++;
        if (obs !== {4'd1, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL inc_on_wrap obs=%b exp=%b", obs, {4'd1, 1'b0, 1'b0, 1'b1});
        end
        levelBus.SC_RegLEVEL_op_InBUS = 3'b000;
        for (int e = 0; e < 7; e++) tick();
        checks++;
        if (obs !== {4'd1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL pre_wrap obs=%b exp=%b", obs, {4'd1, 1'b0, 1'b0, 1'b0});
        end
        levelBus.SC_RegLEVEL_load_InLow = 1'b0;
        levelBus.SC_RegLEVEL_data_InBUS = 4'd3;
        tick();
        checks++;
        if (obs !== {4'd3, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL load_on_wrap obs=%b exp=%b", obs, {4'd3, 1'b0, 1'b0, 1'b1});
        end
        levelBus.SC_RegLEVEL_load_InLow = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            exp = {(j == 7) ? 4'd4 : 4'd3, 1'b0, 1'b0, (j == 7)};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL after_load_%0d obs=%b exp=%b", j, obs, exp);
            end
        end
    endtask

    task automatic test_reset_coincident();
        idle();
        levelBus.SC_RegLEVEL_load_InLow = 1'b0;
        levelBus.SC_RegLEVEL_data_InBUS = 4'd2;
        tick();
        idle();
        levelBus.SC_RegLEVEL_autoEn_InHigh = 1'b1;
        for (int e = 0; e < 7; e++) tick();
        rst = 1'b1;
        levelBus.SC_RegLEVEL_load_InLow = 1'b0;
        levelBus.SC_RegLEVEL_clear_InLow = 1'b0;
        levelBus.SC_RegLEVEL_data_InBUS = 4'd7;
        tick();
        checks++;
        if (obs !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_on_wrap obs=%b exp=%b", obs, {4'd0, 1'b0, 1'b1, 1'b0});
        end
        rst = 1'b0;
        levelBus.SC_RegLEVEL_load_InLow = 1'b1;
        levelBus.SC_RegLEVEL_clear_InLow = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            exp = {(j == 7) ? 4'd1 : 4'd0, 1'b0, (j != 7), (j == 7)};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL post_reset_%0d obs=%b exp=%b", j, obs, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle();
        test_reset();
        test_saturate();
        test_rotate_shift();
        test_auto();
        test_back_to_back();
        test_reset_coincident();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
